turn_scheduler: RTL

- Sequences one blackjack round for the master console: initial deal, player turn, dealer turn, result.
- Arbitrates the single shared card source between the player and dealer hands with a req/ack handshake.
- Active only when the role selector reports MAIN_PLAYER (2'b01). In IDLE (2'b00) or SIDE_PLAYER (2'b11) it stays idle and never requests cards.

---
 rtl/blackjack_pkg.sv | 39 +++
 rtl/hand_accumulator.sv | 44 ++++
 rtl/turn_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/blackjack_pkg.sv
// Shared encodings and score arithmetic for the blackjack console.
// The round scheduler and its hand accumulators both import this package.
package blackjack_pkg;

  localparam int CARD_W  = 4;
  localparam int SCORE_W = 5;

  typedef enum logic [1:0] {
    ROLE_IDLE = 2'b00,
    ROLE_MAIN = 2'b01,
    ROLE_SIDE = 2'b11
  } role_e;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEAL_P1,
    ST_DEAL_D1,
    ST_DEAL_P2,
    ST_DEAL_D2,
    ST_PLAYER_TURN,
    ST_PLAYER_DRAW,
    ST_DEALER_CHECK,
    ST_DEALER_DRAW,
    ST_RESULT
  } state_e;

  // An ace counts as 11 only while that cannot push the hand past 21.
  function automatic logic [SCORE_W-1:0] eff_score(input logic [SCORE_W-1:0] hard,
                                                    input logic               ace);
    if (ace && (hard <= 5'd11)) return hard + 5'd10;
    return hard;
  endfunction

endpackage

// File: rtl/hand_accumulator.sv
// One blackjack hand: saturating hard sum plus an ace flag.
// eff_next_o previews the effective score if value_i were added this cycle.
module hand_accumulator
  import blackjack_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               add_i,
  input  logic [CARD_W-1:0]  value_i,
  output logic [SCORE_W-1:0] hard_o,
  output logic               has_ace_o,
  output logic [SCORE_W-1:0] eff_next_o
);

  logic [SCORE_W-1:0] hard_q, hard_d;
  logic               ace_q, ace_d;
  logic [CARD_W-1:0]  card;
  logic [SCORE_W:0]   sum;

  // Out-of-range card codes are scored as a ten-value card.
  assign card = ((value_i == 4'd0) || (value_i > 4'd10)) ? 4'd10 : value_i;
  assign sum  = {1'b0, hard_q} + {2'b00, card};

  always_comb begin
    hard_d = (sum > 6'd31) ? 5'd31 : sum[SCORE_W-1:0];
    ace_d  = ace_q | (card == 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      hard_q <= '0;
      ace_q  <= 1'b0;
    end else if (add_i) begin
      hard_q <= hard_d;
      ace_q  <= ace_d;
    end
  end

  assign hard_o     = hard_q;
  assign has_ace_o  = ace_q;
  assign eff_next_o = eff_score(hard_d, ace_d);

endmodule

// File: rtl/turn_scheduler.sv
// Round sequencer for the master console: deal, player turn, dealer turn, result.
// Owns the shared card source handshake and both hand accumulators.
module turn_scheduler
  import blackjack_pkg::*;
#(
  parameter int DEALER_STAND = 17,
  parameter int BLACKJACK    = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        selected_player,
  input  logic              start,
  input  logic              hit,
  input  logic              stand,
  input  logic              new_round,
  output logic              card_req,
  input  logic              card_ack,
  input  logic [CARD_W-1:0] card_value,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] dealer_score,
  output logic              player_turn,
  output logic [1:0]        result,
  output logic              result_valid
);

  localparam logic [SCORE_W-1:0] STAND_L = SCORE_W'(DEALER_STAND);
  localparam logic [SCORE_W-1:0] BJ_L    = SCORE_W'(BLACKJACK);

  state_e             state_q, state_d;
  logic               card_req_q, card_req_d;
  logic [1:0]         result_q, result_d;
  logic [SCORE_W-1:0] player_score_q, dealer_score_q;
  logic               player_turn_q, result_valid_q;

  logic               active, ack_ok, clear_hands, p_add, d_add;
  logic [SCORE_W-1:0] p_hard, d_hard, p_eff, d_eff, p_eff_next, d_eff_next;
  logic               p_ace, d_ace;

  hand_accumulator u_player (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_hands),
    .add_i      (p_add),
    .value_i    (card_value),
    .hard_o     (p_hard),
    .has_ace_o  (p_ace),
    .eff_next_o (p_eff_next)
  );

  hand_accumulator u_dealer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_hands),
    .add_i      (d_add),
    .value_i    (card_value),
    .hard_o     (d_hard),
    .has_ace_o  (d_ace),
    .eff_next_o (d_eff_next)
  );

  assign p_eff  = eff_score(p_hard, p_ace);
  assign d_eff  = eff_score(d_hard, d_ace);
  assign active = (selected_player == ROLE_MAIN);
  // Acks are only meaningful while a request is outstanding.
  assign ack_ok = card_req_q && card_ack;

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    clear_hands = 1'b0;
    p_add       = 1'b0;
    d_add       = 1'b0;

    if ((state_q != ST_IDLE) && !active) begin
      state_d     = ST_IDLE;
      result_d    = RES_NONE;
      clear_hands = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && active) begin
            state_d     = ST_DEAL_P1;
            result_d    = RES_NONE;
            clear_hands = 1'b1;
          end
        end
        ST_DEAL_P1: if (ack_ok) begin p_add = 1'b1; state_d = ST_DEAL_D1; end
        ST_DEAL_D1: if (ack_ok) begin d_add = 1'b1; state_d = ST_DEAL_P2; end
        ST_DEAL_P2: if (ack_ok) begin p_add = 1'b1; state_d = ST_DEAL_D2; end
        ST_DEAL_D2: if (ack_ok) begin d_add = 1'b1; state_d = ST_PLAYER_TURN; end
        ST_PLAYER_TURN: begin
          if (p_eff == BJ_L)  state_d = ST_DEALER_CHECK;
          else if (stand)     state_d = ST_DEALER_CHECK;
          else if (hit)       state_d = ST_PLAYER_DRAW;
        end
        ST_PLAYER_DRAW: begin
          if (ack_ok) begin
            p_add = 1'b1;
            if (p_eff_next > BJ_L) begin
              state_d  = ST_RESULT;
              result_d = RES_DEALER;
            end else if (p_eff_next == BJ_L) begin
              state_d = ST_DEALER_CHECK;
            end else begin
              state_d = ST_PLAYER_TURN;
            end
          end
        end
        ST_DEALER_CHECK: begin
          if (d_eff >= STAND_L) begin
            state_d = ST_RESULT;
            if (d_eff > BJ_L)       result_d = RES_PLAYER;
            else if (p_eff > d_eff) result_d = RES_PLAYER;
            else if (p_eff < d_eff) result_d = RES_DEALER;
            else                    result_d = RES_PUSH;
          end else begin
            state_d = ST_DEALER_DRAW;
          end
        end
        ST_DEALER_DRAW: if (ack_ok) begin d_add = 1'b1; state_d = ST_DEALER_CHECK; end
        ST_RESULT:      if (new_round) state_d = ST_IDLE;
        default:        state_d = ST_IDLE;
      endcase
    end

    // Request drops for a cycle after every accepted card, then re-arms
    // if the next state also needs a card.
    card_req_d = 1'b0;
    case (state_d)
      ST_DEAL_P1, ST_DEAL_D1, ST_DEAL_P2, ST_DEAL_D2,
      ST_PLAYER_DRAW, ST_DEALER_DRAW: card_req_d = !ack_ok;
      default:                        card_req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      card_req_q     <= 1'b0;
      result_q       <= RES_NONE;
      player_score_q <= '0;
      dealer_score_q <= '0;
      player_turn_q  <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      card_req_q     <= card_req_d;
      result_q       <= result_d;
      player_score_q <= p_eff;
      dealer_score_q <= d_eff;
      player_turn_q  <= (state_d == ST_PLAYER_TURN);
      result_valid_q <= (state_d == ST_RESULT);
    end
  end

  assign card_req     = card_req_q;
  assign player_score = player_score_q;
  assign dealer_score = dealer_score_q;
  assign player_turn  = player_turn_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule
